// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback stage and a long-latency unit (LLU). Pipeline writes win the
// port. LLU results queue in a small pending FIFO and drain in cycles where
// the pipeline does not write. If the FIFO head waits STARVE_MAX pipeline
// writes, the arbiter stalls the pipeline for one cycle and drains the head.
// When a pipeline write is granted to a register, every queued LLU result for
// that register is squashed. A squashed result is popped without a write.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   pipe_we/waddr/wdata   pipeline WB write request
//   pipe_stall            hold WB this cycle (combinational)
//   ll_valid/waddr/wdata  LLU result offer (held stable until accepted)
//   ll_ready              LLU result accepted this cycle (combinational)
//   rf_we/waddr/wdata     register-file write port (registered)
//   pend_cnt              pending FIFO occupancy (registered)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DW         = 16,
  parameter int AW         = 4,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pipe_we,
  input  logic [AW-1:0]              pipe_waddr,
  input  logic [DW-1:0]              pipe_wdata,
  output logic                       pipe_stall,
  input  logic                       ll_valid,
  input  logic [AW-1:0]              ll_waddr,
  input  logic [DW-1:0]              ll_wdata,
  output logic                       ll_ready,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_waddr,
  output logic [DW-1:0]              rf_wdata,
  output logic [$clog2(DEPTH):0]     pend_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,   // FIFO empty
    PEND  = 2'd1,   // FIFO holds entries, pipeline has priority
    FORCE = 2'd2    // one-cycle forced drain of the FIFO head
  } state_t;

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } entry_t;

  state_t           state, state_nxt;
  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] squash;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [SW-1:0]    starve, starve_nxt;

  logic   pipe_grant;
  logic   pop;
  logic   head_write;
  logic   push;
  entry_t head;
  logic   head_sq;

  assign head    = mem[rd_ptr];
  assign head_sq = squash[rd_ptr];

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pipe_stall = 1'b0;
    pipe_grant = 1'b0;
    pop        = 1'b0;
    starve_nxt = starve;
    state_nxt  = state;

    unique case (state)
      IDLE: begin
        pipe_grant = pipe_we;
      end
      PEND: begin
        pipe_grant = pipe_we;
        // A squashed head leaves without a write, even under pipeline traffic.
        pop        = head_sq || !pipe_we;
      end
      FORCE: begin
        pipe_stall = 1'b1;
        pop        = 1'b1;
      end
      default: ;
    endcase

    head_write = pop && !head_sq;
    // A full FIFO still accepts when its head leaves in the same cycle.
    ll_ready   = (cnt < CW'(DEPTH)) || pop;
    push       = ll_valid && ll_ready;
    cnt_nxt    = cnt + CW'(push) - CW'(pop);

    // The counter measures how long the current head has waited, so any
    // change of head restarts it.
    if (pop)
      starve_nxt = '0;
    else if (state == PEND && pipe_grant)
      starve_nxt = starve + SW'(1);

    if (cnt_nxt == '0)
      state_nxt = IDLE;
    else if (state == FORCE)
      state_nxt = PEND;
    else if (starve_nxt == SW'(STARVE_MAX))
      state_nxt = FORCE;
    else
      state_nxt = PEND;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      starve <= '0;
      squash <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      starve <= starve_nxt;
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      // Older queued results for the same register are now stale. Unused
      // slots may be marked too; a push clears the bit of its slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_grant && mem[i].waddr == pipe_waddr)
          squash[i] <= 1'b1;
      end
      // A result pushed alongside a same-register pipeline write is younger,
      // so it is kept.
      if (push) squash[wr_ptr] <= 1'b0;
    end
  end

  // NOTE: the FIFO payload has no reset; an entry is only read after a push
  // has written it, and occupancy/pointers/squash bits are reset instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{waddr: ll_waddr, wdata: ll_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= pipe_grant || head_write;
      if (pipe_grant) begin
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
      end else if (head_write) begin
        rf_waddr <= head.waddr;
        rf_wdata <= head.wdata;
      end
    end
  end

  assign pend_cnt = cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Drives wb_port_arbiter with directed scenarios followed by randomized
// traffic. A cycle model built on a queue of pending LLU results predicts
// pipe_stall, ll_ready, the registered write port and the occupancy.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int DW         = 16;
  localparam int AW         = 4;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_stall;
  logic          ll_valid;
  logic [AW-1:0] ll_waddr;
  logic [DW-1:0] ll_wdata;
  logic          ll_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [CW-1:0] pend_cnt;

  wb_port_arbiter #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall),
    .ll_valid(ll_valid), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
    .ll_ready(ll_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_cnt(pend_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            dead;   // overwritten by a later pipeline write
  } pend_t;

  pend_t         q[$];
  int            wait_cycles;   // pipeline writes seen by the current head
  bit            stall_next;
  logic          m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;

  task automatic model_reset();
    q.delete();
    wait_cycles = 0;
    stall_next  = 1'b0;
    m_we = 1'b0;
    m_a  = '0;
    m_d  = '0;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance
  // the model, check registered outputs just after the rising edge.
  task automatic step(input bit pw, input logic [AW-1:0] pa,
                      input logic [DW-1:0] pd, input bit lv,
                      input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      output bit took, output bit stalled);
    bit    forcing, granted, leaves, busy, ready;
    pend_t hd;
    @(negedge clk);
    pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    ll_valid = lv; ll_waddr = la; ll_wdata = ld;
    #1;
    forcing = stall_next;
    busy    = q.size() > 0;
    hd      = busy ? q[0] : '{a: '0, d: '0, dead: 1'b0};
    granted = pw && !forcing;
    leaves  = busy && (forcing || hd.dead || !pw);
    ready   = (q.size() < DEPTH) || leaves;
    check("pipe_stall", pipe_stall, forcing);
    check("ll_ready", ll_ready, ready);
    stalled = pipe_stall;
    took    = lv && ll_ready;

    if (granted) begin
      m_we = 1'b1; m_a = pa; m_d = pd;
    end else if (leaves && !hd.dead) begin
      m_we = 1'b1; m_a = hd.a; m_d = hd.d;
    end else begin
      m_we = 1'b0;
    end
    if (granted)
      foreach (q[i]) if (q[i].a == pa) q[i].dead = 1'b1;
    if (leaves) void'(q.pop_front());
    if (lv && ready) q.push_back('{a: la, d: ld, dead: 1'b0});
    if (leaves) wait_cycles = 0;
    else if (granted && busy) wait_cycles++;
    stall_next = !leaves && granted && busy && (wait_cycles == STARVE_MAX);

    @(posedge clk);
    #1;
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_a);
    check("rf_wdata", rf_wdata, m_d);
    check("pend_cnt", pend_cnt, q.size());
  endtask

  task automatic idle_steps(input int n);
    bit tk, st;
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, tk, st);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit            tk, st;
    bit            r_pw, r_lv;
    logic [AW-1:0] r_pa, r_la;
    logic [DW-1:0] r_pd, r_ld;

    rst_n = 1'b0;
    pipe_we = 0; pipe_waddr = '0; pipe_wdata = '0;
    ll_valid = 0; ll_waddr = '0; ll_wdata = '0;
    model_reset();
    #12 rst_n = 1'b1;

    // Reset mid-operation: a write and a pending LLU result are in flight.
    step(1, 4'd9, 16'h0055, 1, 4'd6, 16'h0077, tk, st);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_pend_cnt", pend_cnt, 0);
    pipe_we = 0; ll_valid = 0;
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;

    step(1, 4'd3, 16'h0001, 0, '0, '0, tk, st);
    check("idle_waddr", rf_waddr, 3);
    check("idle_wdata", rf_wdata, 16'h0001);

    // LLU result fills a quiet slot.
    step(0, '0, '0, 1, 4'd5, 16'hBEEF, tk, st);
    check("quiet_push", tk, 1);
    step(0, '0, '0, 0, '0, '0, tk, st);
    check("quiet_we", rf_we, 1);
    check("quiet_waddr", rf_waddr, 5);
    check("quiet_wdata", rf_wdata, 16'hBEEF);
    check("quiet_empty", pend_cnt, 0);

    // Starvation: continuous pipeline writes, one pending LLU result.
    step(0, '0, '0, 1, 4'd8, 16'hCAFE, tk, st);
    for (int i = 0; i < STARVE_MAX; i++)
      step(1, 4'(i + 1), 16'(16'h0100 + i), 0, '0, '0, tk, st);
    step(1, 4'd1, 16'h0200, 0, '0, '0, tk, st);
    check("starve_stall", st, 1);
    check("starve_wdata", rf_wdata, 16'hCAFE);
    step(1, 4'd1, 16'h0200, 0, '0, '0, tk, st);
    check("starve_release", st, 0);

    // Backpressure: two results fill the FIFO; the third waits for a drain.
    step(1, 4'd1, 16'h0301, 1, 4'd10, 16'h1010, tk, st);
    step(1, 4'd2, 16'h0302, 1, 4'd11, 16'h1111, tk, st);
    check("bp_full", pend_cnt, 2);
    tk = 1'b0;
    for (int i = 0; i < 10 && !tk; i++)
      step(1, 4'd3, 16'(16'h0400 + i), 1, 4'd12, 16'h1212, tk, st);
    check("bp_accept", tk, 1);
    check("bp_accept_in_force", st, 1);
    idle_steps(3);

    // WAW squash: a queued r7 result is overwritten by the pipeline.
    step(1, 4'd1, 16'h0501, 1, 4'd7, 16'h1111, tk, st);
    step(1, 4'd7, 16'h2222, 0, '0, '0, tk, st);
    step(0, '0, '0, 0, '0, '0, tk, st);
    check("waw_no_we", rf_we, 0);
    check("waw_wdata", rf_wdata, 16'h2222);
    check("waw_empty", pend_cnt, 0);

    // Same-cycle push and pipeline write to r2: pipeline first, LLU second.
    step(1, 4'd2, 16'hAAAA, 1, 4'd2, 16'hBBBB, tk, st);
    check("same_first", rf_wdata, 16'hAAAA);
    step(0, '0, '0, 0, '0, '0, tk, st);
    check("same_second_we", rf_we, 1);
    check("same_second", rf_wdata, 16'hBBBB);

    // Randomized traffic; small address range to provoke squashes.
    r_lv = 1'b0; r_pw = 1'b0; st = 1'b0;
    r_la = '0; r_ld = '0; r_pa = '0; r_pd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!st) begin   // a stalled pipeline holds its request
        r_pw = $urandom_range(0, 3) != 0;
        r_pa = 4'($urandom_range(0, 3));
        r_pd = 16'($urandom);
      end
      if (!r_lv) begin // the LLU holds its offer until accepted
        r_lv = $urandom_range(0, 2) != 0;
        r_la = 4'($urandom_range(0, 3));
        r_ld = 16'($urandom);
      end
      step(r_pw, r_pa, r_pd, r_lv, r_la, r_ld, tk, st);
      if (tk) r_lv = 1'b0;
    end
    idle_steps(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (LLU: multiplier/divider/load return).
- Pipeline writes have priority. LLU results wait in a small pending FIFO.
- A starvation timer forces a one-cycle pipeline stall so that a waiting LLU result can drain.
- Sits between the WB stage outputs (write enable, destination address, writeback data) and the register file write port.

Parameters:
- DW, 16, data width of writeback value
- AW, 4, register address width
- DEPTH, 2, pending FIFO entries (power of 2, at least 2)
- STARVE_MAX, 4, cycles an LLU result may wait at FIFO head before a forced drain (at least 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pipe_we  in  1  pipeline WB requests a write this cycle
- pipe_waddr  in  AW  pipeline destination register
- pipe_wdata  in  DW  pipeline writeback value
- pipe_stall  out  1  pipeline must hold WB this cycle (combinational)
- ll_valid  in  1  LLU result available
- ll_waddr  in  AW  LLU destination register
- ll_wdata  in  DW  LLU result value
- ll_ready  out  1  arbiter accepts the LLU result this cycle (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write address (registered)
- rf_wdata  out  DW  register-file write data (registered)
- pend_cnt  out  log2(DEPTH)+1  FIFO occupancy (registered)

Behaviour:
- Reset is asynchronous and active-low, with one clock. On rst_n=0: rf_we=0, rf_waddr=0, rf_wdata=0, pend_cnt=0, FIFO emptied, starvation counter=0, state=IDLE. Reset mid-operation discards all pending LLU results.
- All writes have 1-cycle latency. A request granted in cycle N appears on rf_* after edge N+1. rf_we=0 in any cycle with no grant; rf_waddr and rf_wdata hold their last values.
- LLU handshake: the transfer occurs when ll_valid && ll_ready. ll_ready = (pend_cnt < DEPTH) || drain_this_cycle, so a full FIFO accepts when its head drains in the same cycle. The LLU holds ll_valid and its data stable until the transfer.
- LLU results always enter the FIFO tail. They are never written directly to the port.
- State IDLE (FIFO empty):
  - pipe_we is granted.
  - A push moves the state to PEND.
- State PEND (FIFO non-empty):
  - If pipe_we=1: the pipeline is granted and the starvation counter increments.
  - If pipe_we=0: the FIFO head is granted (drained) and the counter clears.
  - When the counter reaches STARVE_MAX, the next state is FORCE.
  - When the FIFO becomes empty, the next state is IDLE.
- State FORCE:
  - pipe_stall=1.
  - The FIFO head is granted unconditionally and the counter clears.
  - Next state is PEND if entries remain, else IDLE.
  - FORCE lasts exactly one cycle.
- pipe_stall=0 in IDLE and PEND.
- Ordering hazard (WAW): when a pipeline write is granted to address A, every FIFO entry with waddr==A is squashed.
  - Squashed entries are marked invalid and skipped (popped with no write) when they reach the head.
  - A squashed head pops in the same cycle with no port write. It does not count as a drain for the starvation counter.
  - The counter resets when the head changes.
- An LLU push in the same cycle as a pipeline write to the same address is not squashed: the LLU result is younger.
- Simultaneous push and pop: occupancy is unchanged and the pointers wrap modulo DEPTH.
- pend_cnt counts valid and squashed entries until they pop.
- An address-0 write is treated like any other address. Register-0 semantics belong to the register file.

Test Plan:
- Reset / idle: assert rst_n=0 mid-write, then release. Required: rf_we=0, rf_waddr=0, pend_cnt=0 immediately, without a clock edge. Then pipe_we=1, waddr=3, wdata=16'h0001 → next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h0001.
- LLU fills a quiet slot: ll_valid=1, waddr=5, data=16'hBEEF with pipe_we=0. Required: pushed, then drained on the next cycle, so rf_waddr=5 and rf_wdata=16'hBEEF two cycles after the request. pend_cnt returns to 0.
- Starvation: one LLU entry pending with pipe_we=1 continuously (STARVE_MAX=4). Required: four pipeline writes granted, then pipe_stall=1 for exactly one cycle, with the LLU value on rf_* the following cycle.
- Backpressure: push two LLU results while pipe_we=1 and no forced drain has yet occurred. Required: pend_cnt=2 and ll_ready=0 for a third result until the head drains; the third result is accepted in the drain cycle.
- WAW squash: LLU result to r7 (16'h1111) pending, then pipeline write to r7 (16'h2222). Required: r7 is never written with 16'h1111 afterwards and pend_cnt returns to 0 without an rf_we pulse for the squashed entry.
- Same-cycle push and pipeline write to r2: required order is the pipeline value first, then the LLU value (not squashed).
